// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline constants. Datapath defaults and load-size
//               encodings used by the MA/WB stage and its load aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int RADDR_W_DEFAULT = 5;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Combinational sub-word load extraction. Selects a byte or
//               halfword from the memory read word and zero/sign-extends it.
//               Size 2'b11 is treated as a full word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_size,
  input  logic            i_signed,
  input  logic [1:0]      i_byteOff,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane picked by the full offset; halfword by offset bit 1 only.
  assign w_byte = i_word[{i_byteOff, 3'b000} +: 8];
  assign w_half = i_byteOff[1] ? i_word[31:16] : i_word[15:0];

  // Extend the selected lane according to load size and signedness.
  always_comb begin
    o_data = i_word;
    case (i_size)
      LS_HALF: o_data = {{(XLEN-16){i_signed & w_half[15]}}, w_half};
      LS_BYTE: o_data = {{(XLEN-8){i_signed & w_byte[7]}}, w_byte};
      default: o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ma_wb_stage.sv
// ============================================================================
// Module      : ma_wb_stage
// Description : Memory-access / write-back pipeline register. Captures the
//               data-memory read word, ALU result and write-back controls,
//               drives the register-file write port and counts retired
//               instructions. Define LOAD_SUBWORD_EN to enable byte/half
//               load alignment; otherwise loads are word-only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ma_wb_stage
  import pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = RADDR_W_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic               clkIn,
  input  logic               resetIn,
  input  logic               StallIn,
  input  logic               FlushIn,
  input  logic               ValidIn,
  input  logic [XLEN-1:0]    AluResultIn,
  input  logic [XLEN-1:0]    MemDataIn,
  input  logic               MemToRegIn,
  input  logic               RegWriteIn,
  input  logic [RADDR_W-1:0] DestRegIn,
  input  logic [1:0]         LoadSizeIn,
  input  logic               LoadSignedIn,
  input  logic [1:0]         ByteOffIn,
  output logic [XLEN-1:0]    WbDataOut,
  output logic [RADDR_W-1:0] WbRegOut,
  output logic               WbEnOut,
  output logic               ValidOut,
  output logic [CNT_W-1:0]   RetireCountOut
);

  logic [XLEN-1:0]    w_aligned;
  logic [XLEN-1:0]    w_wbData;
  logic               w_load;

  logic               r_valid;
  logic               r_regWrite;
  logic [XLEN-1:0]    r_wbData;
  logic [RADDR_W-1:0] r_wbReg;
  logic [CNT_W-1:0]   r_retireCnt;

`ifdef LOAD_SUBWORD_EN
  load_align #(
    .XLEN (XLEN)
  ) u_loadAlign (
    .i_word    (MemDataIn),
    .i_size    (LoadSizeIn),
    .i_signed  (LoadSignedIn),
    .i_byteOff (ByteOffIn),
    .o_data    (w_aligned)
  );
`else
  // Word-only build: the sub-word controls are accepted but have no effect.
  logic w_unusedLoadCtl;
  assign w_unusedLoadCtl = ^{LoadSizeIn, LoadSignedIn, ByteOffIn};
  assign w_aligned       = MemDataIn;
`endif

  // A load event is an edge with neither flush nor stall pending.
  assign w_load   = ~FlushIn & ~StallIn;
  assign w_wbData = MemToRegIn ? w_aligned : AluResultIn;

  // Stage register: reset > flush > stall > load.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_wbData   <= '0;
      r_wbReg    <= '0;
    end else if (FlushIn) begin
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
    end else if (!StallIn) begin
      r_valid    <= ValidIn;
      r_regWrite <= RegWriteIn;
      r_wbData   <= w_wbData;
      r_wbReg    <= DestRegIn;
    end
  end

  // Retire counter: counts valid instructions accepted on load events, wraps.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      r_retireCnt <= '0;
    end else if (w_load && ValidIn) begin
      r_retireCnt <= r_retireCnt + 1'b1;
    end
  end

  assign ValidOut       = r_valid;
  assign WbDataOut      = r_wbData;
  assign WbRegOut       = r_wbReg;
  assign RetireCountOut = r_retireCnt;
  // Register 0 is hard-wired and must never be written.
  assign WbEnOut        = r_valid & r_regWrite & (r_wbReg != '0);

endmodule

`default_nettype wire

// File: tb/tb_ma_wb_stage.sv
// ============================================================================
// Module      : tb_ma_wb_stage
// Description : Self-checking bench for ma_wb_stage with a behavioural
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ma_wb_stage;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic               clkIn = 1'b0;
  logic               resetIn = 1'b0;
  logic               StallIn = 1'b0;
  logic               FlushIn = 1'b0;
  logic               ValidIn = 1'b0;
  logic [XLEN-1:0]    AluResultIn = '0;
  logic [XLEN-1:0]    MemDataIn = '0;
  logic               MemToRegIn = 1'b0;
  logic               RegWriteIn = 1'b0;
  logic [RADDR_W-1:0] DestRegIn = '0;
  logic [1:0]         LoadSizeIn = '0;
  logic               LoadSignedIn = 1'b0;
  logic [1:0]         ByteOffIn = '0;
  logic [XLEN-1:0]    WbDataOut;
  logic [RADDR_W-1:0] WbRegOut;
  logic               WbEnOut;
  logic               ValidOut;
  logic [CNT_W-1:0]   RetireCountOut;

  ma_wb_stage #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clkIn          (clkIn),
    .resetIn        (resetIn),
    .StallIn        (StallIn),
    .FlushIn        (FlushIn),
    .ValidIn        (ValidIn),
    .AluResultIn    (AluResultIn),
    .MemDataIn      (MemDataIn),
    .MemToRegIn     (MemToRegIn),
    .RegWriteIn     (RegWriteIn),
    .DestRegIn      (DestRegIn),
    .LoadSizeIn     (LoadSizeIn),
    .LoadSignedIn   (LoadSignedIn),
    .ByteOffIn      (ByteOffIn),
    .WbDataOut      (WbDataOut),
    .WbRegOut       (WbRegOut),
    .WbEnOut        (WbEnOut),
    .ValidOut       (ValidOut),
    .RetireCountOut (RetireCountOut)
  );

  always #5 clkIn = ~clkIn;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load extraction from the load-size rules.
  function automatic logic [31:0] refAlign(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sgn, input logic [1:0] off);
`ifdef LOAD_SUBWORD_EN
    longint unsigned v;
    if (sz == 2'b01) begin
      v = (w >> (int'(off[1]) * 16)) & 32'h0000_FFFF;
      if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v[31:0];
    end else if (sz == 2'b10) begin
      v = (w >> (int'(off) * 8)) & 32'h0000_00FF;
      if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
      return v[31:0];
    end
    return w;
`else
    if (sz == 2'b11 && sgn && off == 2'b11) return w;
    return w;
`endif
  endfunction

  // Behavioural model state
  bit                 live = 0;
  bit                 expValid;
  bit                 expRw;
  bit                 dataKnown;
  logic [XLEN-1:0]    expData;
  logic [RADDR_W-1:0] expReg;
  int                 expCnt;

  // Model update on each rising edge from the stage rules.
  always @(posedge clkIn) begin
    if (resetIn) begin
      live = 1; expValid = 0; expRw = 0; expData = '0; expReg = '0;
      dataKnown = 1; expCnt = 0;
    end else if (live) begin
      if (FlushIn) begin
        expValid = 0; expRw = 0; dataKnown = 0;
      end else if (!StallIn) begin
        expValid  = ValidIn;
        expRw     = RegWriteIn;
        expReg    = DestRegIn;
        expData   = MemToRegIn ? refAlign(MemDataIn, LoadSizeIn, LoadSignedIn, ByteOffIn)
                               : AluResultIn;
        dataKnown = 1;
        if (ValidIn) expCnt = (expCnt + 1) % CNT_MOD;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clkIn) begin
    if (live) begin
      check("ValidOut", ValidOut, expValid);
      check("WbEnOut", WbEnOut, expValid && expRw && (expReg != 0));
      check("RetireCountOut", RetireCountOut, expCnt);
      if (dataKnown) begin
        check("WbDataOut", WbDataOut, expData);
        check("WbRegOut", WbRegOut, expReg);
      end
    end
  end

  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic valid, input logic rw, input logic m2r,
                      input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] alu,
                      input logic [XLEN-1:0] mem, input logic [1:0] sz,
                      input logic sgn, input logic [1:0] off);
    resetIn = rst; StallIn = stall; FlushIn = flush; ValidIn = valid;
    RegWriteIn = rw; MemToRegIn = m2r; DestRegIn = rd; AluResultIn = alu;
    MemDataIn = mem; LoadSizeIn = sz; LoadSignedIn = sgn; ByteOffIn = off;
    @(negedge clkIn);
  endtask

  localparam logic [31:0] MEMW = 32'h80F0_7F01;

  initial begin
    @(negedge clkIn);

    // Reset with a live instruction on the inputs
    step(1, 0, 0, 1, 1, 0, 5'd5, 32'h1234, 0, 2'b00, 0, 2'b00);
    check("reset_valid", ValidOut, 0);
    check("reset_en", WbEnOut, 0);
    check("reset_cnt", RetireCountOut, 0);

    // ALU write-back
    step(0, 0, 0, 1, 1, 0, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 2'b00, 0, 2'b00);
    check("alu_data", WbDataOut, 32'h1234);
    check("alu_reg", WbRegOut, 5);
    check("alu_en", WbEnOut, 1);
    check("alu_cnt", RetireCountOut, 1);

    // Sub-word loads from the same memory word
    step(0, 0, 0, 1, 1, 1, 5'd3, 32'h0, MEMW, 2'b10, 1, 2'b10);
`ifdef LOAD_SUBWORD_EN
    check("lb_signed", WbDataOut, 32'hFFFF_FFF0);
`else
    check("lb_word_only", WbDataOut, 32'h80F0_7F01);
`endif
    step(0, 0, 0, 1, 1, 1, 5'd3, 32'h0, MEMW, 2'b10, 0, 2'b10);
`ifdef LOAD_SUBWORD_EN
    check("lbu", WbDataOut, 32'h0000_00F0);
`else
    check("lbu_word_only", WbDataOut, 32'h80F0_7F01);
`endif
    step(0, 0, 0, 1, 1, 1, 5'd3, 32'h0, MEMW, 2'b01, 1, 2'b10);
`ifdef LOAD_SUBWORD_EN
    check("lh_signed", WbDataOut, 32'hFFFF_80F0);
`else
    check("lh_word_only", WbDataOut, 32'h80F0_7F01);
`endif
    check("load_cnt", RetireCountOut, 4);

    // Instruction A to r7, then stall three cycles with B on the inputs
    step(0, 0, 0, 1, 1, 0, 5'd7, 32'h0000_00A7, 0, 2'b00, 0, 2'b00);
    check("A_cnt", RetireCountOut, 5);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 1, 0, 5'd9, 32'h0000_00B9, 0, 2'b00, 0, 2'b00);
      check("stall_data", WbDataOut, 32'hA7);
      check("stall_reg", WbRegOut, 7);
      check("stall_en", WbEnOut, 1);
      check("stall_cnt", RetireCountOut, 5);
    end
    step(0, 1, 1, 1, 1, 0, 5'd9, 32'h0000_00B9, 0, 2'b00, 0, 2'b00);
    check("flush_valid", ValidOut, 0);
    check("flush_en", WbEnOut, 0);
    check("flush_cnt", RetireCountOut, 5);

    // Register 0 destination, then a bubble
    step(0, 0, 0, 1, 1, 0, 5'd0, 32'h55, 0, 2'b00, 0, 2'b00);
    check("r0_en", WbEnOut, 0);
    check("r0_cnt", RetireCountOut, 6);
    step(0, 0, 0, 0, 1, 0, 5'd4, 32'h66, 0, 2'b00, 0, 2'b00);
    check("bubble_en", WbEnOut, 0);
    check("bubble_cnt", RetireCountOut, 6);

    // Counter wrap with a 4-bit counter
    step(1, 0, 0, 0, 0, 0, 5'd0, 0, 0, 2'b00, 0, 2'b00);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 1, 0, 5'(i + 1), 32'(i), 0, 2'b00, 0, 2'b00);
      if (i == 14) check("cnt_15", RetireCountOut, 15);
    end
    check("cnt_wrap", RetireCountOut, 0);

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 50) == 0, ($urandom % 5) == 0, ($urandom % 9) == 0,
           ($urandom % 4) != 0, $urandom % 2, $urandom % 2,
           5'($urandom), $urandom, $urandom, 2'($urandom), $urandom % 2, 2'($urandom));
    end

    step(0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 2'b00, 0, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
